res_stream_buffer: RTL and testbench
====================================

RES_STREAM_BUFFER -- requirements
Module: res_stream_buffer

Interface
REQ-001 Parameter BIT_DEPTH, default 8, SHALL set the width of one result word.
REQ-002 Parameter LANES, default 4, SHALL set the number of words per row; legal range is >= 2.
REQ-003 Parameter DEPTH, default 16, SHALL set the row capacity; it SHALL be a power of two >= 2.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 flush  input  1  SHALL be a synchronous clear of all buffered content.
REQ-007 wr_valid  input  1  SHALL indicate that wr_data holds a row offered for storage.
REQ-008 wr_data  input  LANES*BIT_DEPTH  SHALL carry one row; lane k occupies bits [k*BIT_DEPTH +: BIT_DEPTH].
REQ-009 wr_ready  output  1  SHALL indicate that a row can be accepted.
REQ-010 rd_valid  output  1  SHALL indicate that rd_data holds a valid word.
REQ-011 rd_ready  input  1  SHALL indicate that the consumer takes rd_data.
REQ-012 rd_data  output  BIT_DEPTH  SHALL carry the current output word.
REQ-013 rd_last  output  1  SHALL flag the final lane (LANES-1) of a row.
REQ-014 count  output  $clog2(DEPTH)+1  SHALL report the number of rows stored, including the row being serialized.
REQ-015 full / empty  output  1 each  SHALL report count==DEPTH and count==0, respectively.
REQ-016 drop_err  output  1  SHALL be a sticky flag for a write attempted while full.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH rows with write pointer, read pointer, and count.
REQ-018 A row write SHALL occur on a clock edge where wr_valid && wr_ready; wr_ready = !full && !flush.
REQ-019 Once accepted, row data SHALL be visible at the read port on the cycle after the accepting edge: 1-cycle write-to-rd_valid latency when empty.
REQ-020 rd_valid SHALL equal !empty.
REQ-021 rd_data SHALL be lane lane_idx of the head row; this read path is combinational from registered storage.
REQ-022 rd_last SHALL equal rd_valid && (lane_idx == LANES-1).
REQ-023 On each edge with rd_valid && rd_ready, lane_idx SHALL increment.
REQ-024 When rd_last is high on that edge, lane_idx SHALL return to 0, the read pointer SHALL advance, and the row SHALL be popped.
REQ-025 Each pointer SHALL wrap from DEPTH-1 to 0.
REQ-026 A simultaneous write and pop in one cycle SHALL leave count unchanged and move both pointers.
REQ-027 While full, a write SHALL NOT be accepted even if a pop occurs in the same cycle.
REQ-028 An edge with wr_valid && full SHALL set drop_err; drop_err SHALL clear only on rst or flush.
REQ-029 flush SHALL take priority over writes and reads in the same cycle: pointers, count, and lane_idx go to 0 and drop_err clears.
REQ-030 Storage contents SHALL NOT be cleared by flush or rst.
REQ-031 rd_data SHALL hold stable while rd_valid && !rd_ready.
REQ-032 A rd_ready asserted while empty SHALL have no effect.

Reset
REQ-033 rst SHALL asynchronously set pointers, count, and lane_idx to 0 and drop_err to 0.
REQ-034 Consequently, during reset: wr_ready=1 (if flush=0), rd_valid=0, rd_last=0, empty=1, full=0, count=0.
REQ-035 An rst asserted mid-row SHALL discard the partially read row and all stored rows.
REQ-036 After rst deasserts, the first accepted write SHALL be stored at row 0.

Verification
REQ-037 Single row: LANES=4, BIT_DEPTH=8. Write 0x44332211 with rd_ready=1 -> rd_data 0x11,0x22,0x33,0x44 on four consecutive cycles starting 1 cycle after the write; rd_last high on 0x44 only; count ends at 0.
REQ-038 Fill and overflow: DEPTH=16, rd_ready=0, write 17 rows -> full=1 and count=16 after the 16th; wr_ready=0; the 17th attempt sets drop_err=1; stored data unchanged.
REQ-039 Wrap and concurrency: stream 40 rows with random wr_valid and rd_ready -> output word order matches input lane order exactly, and count never exceeds 16.
REQ-040 Backpressure: hold rd_ready=0 for 5 cycles mid-row (lane 2) -> rd_data stays the lane-2 value, and lane_idx and count do not change.
REQ-041 Flush: with 3 rows stored, assert flush together with wr_valid and rd_ready -> next cycle count=0, empty=1, and no write or pop occurred.
REQ-042 Async reset: assert rst between clock edges while lane 1 of a row is presented -> rd_valid drops immediately (before the next edge), count=0, drop_err=0.

Source files
------------

// File: rtl/res_stream_buffer_if.sv
// Row-in / word-out stream interface for res_stream_buffer.
// The master is the producer/consumer side. The slave is the buffer.
interface res_stream_buffer_if #(
    parameter int unsigned BIT_DEPTH = 8,
    parameter int unsigned LANES     = 4
);
    logic                         wr_valid;
    logic [LANES*BIT_DEPTH-1:0]   wr_data;
    logic                         wr_ready;
    logic                         rd_valid;
    logic                         rd_ready;
    logic [BIT_DEPTH-1:0]         rd_data;
    logic                         rd_last;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/res_stream_buffer.sv
// res_stream_buffer: circular buffer of DEPTH rows, each holding LANES words.
// Rows enter whole and leave one word per handshake, lane 0 first.
// Pointers and counters reset asynchronously. Row storage is never cleared.
module res_stream_buffer #(
    parameter int unsigned BIT_DEPTH = 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    res_stream_buffer_if.slave       bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     drop_err
);
    localparam int unsigned ROW_W  = LANES * BIT_DEPTH;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned LANE_W = $clog2(LANES);

    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);

    // Row storage and bookkeeping
    logic [ROW_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [LANE_W-1:0]  r_lane_idx;
    logic               r_drop_err;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_ready;
    logic               w_wr_en;
    logic               w_rd_fire;
    logic               w_last;
    logic               w_pop;
    logic [ROW_W-1:0]   w_head_row;
    logic [BIT_DEPTH-1:0] w_lane_words [LANES];

    // Occupancy flags and handshake qualifiers
    always_comb begin
        w_full     = (r_count == FULL_COUNT);
        w_empty    = (r_count == '0);
        w_wr_ready = !w_full && !flush;
        w_wr_en    = bus.wr_valid && w_wr_ready;
        w_rd_fire  = !w_empty && bus.rd_ready;
        w_last     = !w_empty && (r_lane_idx == LAST_LANE);
        w_pop      = w_rd_fire && w_last && !flush;
    end

    // Split the head row into lanes so the output word is a simple mux
    always_comb begin
        w_head_row = r_mem[r_rd_ptr];
        for (int k = 0; k < int'(LANES); k++) begin
            w_lane_words[k] = w_head_row[k*BIT_DEPTH +: BIT_DEPTH];
        end
    end

    // Row storage write. Left unreset so that the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers, occupancy, lane position and sticky drop flag. Flush wins over traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lane_idx <= '0;
            r_drop_err <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lane_idx <= '0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_fire) begin
                if (w_last) begin
                    r_lane_idx <= '0;
                    r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                end else begin
                    r_lane_idx <= r_lane_idx + LANE_W'(1);
                end
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (bus.wr_valid && w_full) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    // Output drive. The read word is combinational from the registered head row and lane.
    always_comb begin
        bus.wr_ready = w_wr_ready;
        bus.rd_valid = !w_empty;
        bus.rd_data  = w_lane_words[r_lane_idx];
        bus.rd_last  = w_last;
        count        = r_count;
        full         = w_full;
        empty        = w_empty;
        drop_err     = r_drop_err;
    end
endmodule

// File: tb/tb_res_stream_buffer.sv
// Testbench for res_stream_buffer. A row-queue reference model and a word scoreboard
// supply every expected value. The bench uses the default parameters (8-bit words, 4 lanes, 16 rows).
module tb_res_stream_buffer;
    localparam int unsigned BD    = 8;
    localparam int unsigned LN    = 4;
    localparam int unsigned DP    = 16;
    localparam int unsigned ROW_W = LN * BD;
    localparam int unsigned CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             drop_err;

    res_stream_buffer_if #(.BIT_DEPTH(BD), .LANES(LN)) bus ();

    res_stream_buffer #(.BIT_DEPTH(BD), .LANES(LN), .DEPTH(DP)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the stored rows in arrival order, the lane of the head row, and the sticky drop flag
    logic [ROW_W-1:0] m_rows [$];
    int               m_lane;
    bit               m_drop;

    function automatic logic [BD-1:0] lane_of(input logic [ROW_W-1:0] row, input int k);
        logic [ROW_W-1:0] tmp;
        tmp = row >> (k * BD);
        return tmp[BD-1:0];
    endfunction

    function automatic logic [BD-1:0] exp_data();
        if (m_rows.size() == 0) return '0;
        return lane_of(m_rows[0], m_lane);
    endfunction

    function automatic bit exp_last();
        return (m_rows.size() != 0) && (m_lane == LN - 1);
    endfunction

    task automatic model_clear();
        m_rows.delete();
        m_lane = 0;
        m_drop = 1'b0;
    endtask

    // Apply the rules for one rising edge, using the inputs currently driven
    task automatic model_edge();
        bit is_full;
        bit pop;
        is_full = (m_rows.size() == DP);
        pop     = 1'b0;
        if (flush) begin
            model_clear();
        end else begin
            if (bus.wr_valid && is_full) m_drop = 1'b1;
            if (m_rows.size() != 0 && bus.rd_ready) begin
                if (m_lane == LN - 1) begin
                    pop    = 1'b1;
                    m_lane = 0;
                end else begin
                    m_lane++;
                end
            end
            if (pop) void'(m_rows.pop_front());
            if (bus.wr_valid && !is_full) m_rows.push_back(bus.wr_data);
        end
    endtask

    task automatic drive(input bit wv, input logic [ROW_W-1:0] wd, input bit rr, input bit fl);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        flush        = fl;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got=%b exp=1", bus.wr_ready); end
        n_tests++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
        n_tests++; if (bus.rd_last !== 1'b0) begin n_fail++; $display("FAIL reset_rd_last got=%b exp=0", bus.rd_last); end
        n_tests++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
        n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_tests++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL reset_drop_err got=%b exp=0", drop_err); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_row();
        logic [ROW_W-1:0] row;
        row = 32'h4433_2211;
        drive(1'b1, row, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if (bus.wr_ready !== 1'b1 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_pre got wr_ready=%b rd_valid=%b exp 1 0", bus.wr_ready, bus.rd_valid); end
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < int'(LN); i++) begin
            logic [BD-1:0] want;
            want = BD'(8'h11 * (i + 1));
            @(negedge clk);
            n_tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== want) begin n_fail++; $display("FAIL single_word%0d got valid=%b data=%h exp valid=1 data=%h", i, bus.rd_valid, bus.rd_data, want); end
            n_tests++; if (bus.rd_last !== (i == int'(LN) - 1)) begin n_fail++; $display("FAIL single_last%0d got=%b exp=%b", i, bus.rd_last, (i == int'(LN) - 1)); end
            tick();
        end
        @(negedge clk);
        n_tests++; if (count !== '0 || empty !== 1'b1 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_end got count=%0d empty=%b valid=%b exp 0 1 0", count, empty, bus.rd_valid); end
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_backpressure();
        logic [ROW_W-1:0] row;
        row = $urandom();
        drive(1'b1, row, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++; if (bus.rd_data !== lane_of(row, 2) || bus.rd_last !== 1'b0 || count !== 5'd1) begin
                n_fail++; $display("FAIL backpressure_hold%0d got data=%h last=%b count=%0d exp data=%h last=0 count=1", c, bus.rd_data, bus.rd_last, count, lane_of(row, 2));
            end
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int k = 2; k < int'(LN); k++) begin
            @(negedge clk);
            n_tests++; if (bus.rd_data !== lane_of(row, k) || bus.rd_last !== (k == int'(LN) - 1)) begin
                n_fail++; $display("FAIL backpressure_resume%0d got data=%h last=%b exp data=%h", k, bus.rd_data, bus.rd_last, lane_of(row, k));
            end
            tick();
        end
        @(negedge clk);
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL backpressure_empty got=%b exp=1", empty); end
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_fill_overflow();
        logic [ROW_W-1:0] first;
        first = '0;
        for (int r = 0; r < int'(DP) + 1; r++) begin
            logic [ROW_W-1:0] row;
            row = $urandom();
            if (r == 0) first = row;
            drive(1'b1, row, 1'b0, 1'b0);
            @(negedge clk);
            n_tests++; if (bus.wr_ready !== (r < int'(DP))) begin n_fail++; $display("FAIL fill_wr_ready%0d got=%b exp=%b", r, bus.wr_ready, (r < int'(DP))); end
            tick();
            n_tests++; if (int'(count) !== m_rows.size()) begin n_fail++; $display("FAIL fill_count%0d got=%0d exp=%0d", r, count, m_rows.size()); end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++; if (full !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL fill_full got full=%b count=%0d exp full=1 count=16", full, count); end
        n_tests++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL fill_drop_err got=%b exp=1", drop_err); end
        n_tests++; if (bus.rd_data !== lane_of(first, 0)) begin n_fail++; $display("FAIL fill_head got=%h exp=%h", bus.rd_data, lane_of(first, 0)); end
    endtask

    task automatic test_async_reset();
        logic [ROW_W-1:0] head;
        logic [ROW_W-1:0] row;
        head = m_rows[0];
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++; if (bus.rd_data !== lane_of(head, 1)) begin n_fail++; $display("FAIL areset_lane1 got=%h exp=%h", bus.rd_data, lane_of(head, 1)); end
        rst = 1'b1;
        model_clear();
        #1;
        n_tests++; if (bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0) begin n_fail++; $display("FAIL areset_valid got valid=%b last=%b exp 0 0", bus.rd_valid, bus.rd_last); end
        n_tests++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL areset_count got count=%0d empty=%b full=%b exp 0 1 0", count, empty, full); end
        n_tests++; if (drop_err !== 1'b0 || bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL areset_drop got drop=%b wr_ready=%b exp 0 1", drop_err, bus.wr_ready); end
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        row = $urandom();
        drive(1'b1, row, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < int'(LN); k++) begin
            @(negedge clk);
            n_tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== lane_of(row, k)) begin
                n_fail++; $display("FAIL areset_after%0d got valid=%b data=%h exp data=%h", k, bus.rd_valid, bus.rd_data, lane_of(row, k));
            end
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_flush();
        for (int r = 0; r < 3; r++) begin
            drive(1'b1, $urandom(), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        drive(1'b1, $urandom(), 1'b1, 1'b1);
        @(negedge clk);
        n_tests++; if (bus.wr_ready !== 1'b0 || count !== 5'd3) begin n_fail++; $display("FAIL flush_pre got wr_ready=%b count=%0d exp 0 3", bus.wr_ready, count); end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++; if (count !== '0 || empty !== 1'b1 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_post got count=%0d empty=%b valid=%b exp 0 1 0", count, empty, bus.rd_valid); end
        n_tests++; if (int'(count) !== m_rows.size()) begin n_fail++; $display("FAIL flush_model got=%0d exp=%0d", count, m_rows.size()); end
        tick();
    endtask

    task automatic test_wrap_random();
        logic [BD-1:0] words [$];
        int  sent;
        int  cyc;
        bit  wv;
        bit  rr;
        logic [ROW_W-1:0] wd;
        sent = 0;
        cyc  = 0;
        words.delete();
        while (!(sent == 40 && m_rows.size() == 0) && cyc < 3000) begin
            wv = (sent < 40) && ($urandom_range(0, 99) < 60);
            wd = $urandom();
            rr = $urandom_range(0, 99) < ((cyc < 150) ? 35 : 85);
            drive(wv, wd, rr, 1'b0);
            @(negedge clk);
            n_tests++; if (int'(count) !== m_rows.size() || count > 5'd16) begin n_fail++; $display("FAIL rand_count c%0d got=%0d exp=%0d", cyc, count, m_rows.size()); end
            n_tests++; if (bus.rd_valid !== (m_rows.size() != 0) || bus.rd_last !== exp_last()) begin
                n_fail++; $display("FAIL rand_flags c%0d got valid=%b last=%b exp valid=%b last=%b", cyc, bus.rd_valid, bus.rd_last, (m_rows.size() != 0), exp_last());
            end
            n_tests++; if (full !== (m_rows.size() == DP) || bus.wr_ready !== (m_rows.size() != DP) || drop_err !== m_drop) begin
                n_fail++; $display("FAIL rand_status c%0d got full=%b wr_ready=%b drop=%b exp full=%b drop=%b", cyc, full, bus.wr_ready, drop_err, (m_rows.size() == DP), m_drop);
            end
            if (bus.rd_valid && rr) begin
                n_tests++;
                if (words.size() == 0 || bus.rd_data !== words[0] || bus.rd_data !== exp_data()) begin
                    n_fail++; $display("FAIL rand_data c%0d got=%h exp=%h", cyc, bus.rd_data, (words.size() != 0) ? words[0] : 8'h0);
                end
                if (words.size() != 0) void'(words.pop_front());
            end
            if (wv && m_rows.size() != DP) begin
                for (int k = 0; k < int'(LN); k++) words.push_back(lane_of(wd, k));
                sent++;
            end
            tick();
            cyc++;
        end
        n_tests++; if (cyc >= 3000) begin n_fail++; $display("FAIL rand_timeout got sent=%0d left=%0d exp completion", sent, m_rows.size()); end
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        model_clear();
        test_reset();
        test_single_row();
        test_backpressure();
        test_fill_overflow();
        test_async_reset();
        test_flush();
        test_wrap_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
